cond_exec_unit: RTL and testbench

Parametrised conditional-execution unit for the ARM-style datapath. It holds banked NZCV flag registers and evaluates the 4-bit condition field against the selected bank, treating cond 1111 as never-execute instead of undefined. It gates the PC/register/memory write enables, updates flags under split write enables, and optionally runs an IT-style predication block over the next N instructions. It sits between decode and the register file/memory write ports.

---
 rtl/cond_pkg.sv | 36 +++
 rtl/cond_eval.sv | 43 ++++
 rtl/cond_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_cond_exec_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: shared types and constants for the conditional-execution unit.
//   cond_e      - ARM 4-bit condition field encodings (NV = 1111, never executes)
//   N/Z/C/V_IDX - bit positions of each flag inside a packed {N,Z,C,V} nibble
//   it_state_e  - predication block state (idle / active)
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic [0:0] {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational ARM condition evaluator.
// Ports:
//   flags - {N,Z,C,V} to test against
//   cond  - 4-bit condition field
//   pass  - 1 when the condition holds; NV (1111) always yields 0
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;   // NV: treated as never-execute
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: banked NZCV flags, condition evaluation, write-enable gating
// and an optional IT-style predication block.
// Build option: define COND_IT_BLOCK_EN to build the predication FSM; without it
// the block inputs are ignored and it_active_o / it_remaining_o read 0.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   valid_i, stall_i      - instruction present / pipeline hold
//   flush_i               - abort an active predication block
//   cond_i, bank_sel_i    - condition field and flag bank used by the instruction
//   alu_flags_i, flag_w_i - new {N,Z,C,V} and split write enables ([1]=NZ, [0]=CV)
//   pcs_i, reg_w_i, mem_w_i, no_write_i - decoded write requests
//   it_start_i, it_len_i, it_cond_i     - predication block open request
//   cond_ex_o             - instruction executes
//   pc_src_o, reg_write_o, mem_write_o  - gated write enables
//   flags_o               - registered NZCV of the selected bank
//   it_active_o, it_remaining_o         - predication block status
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter  int NUM_BANKS = 2,
    parameter  int IT_MAX    = 4,
    localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LW        = $clog2(IT_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic [3:0]    cond_i,
    input  logic [BW-1:0] bank_sel_i,
    input  logic [3:0]    alu_flags_i,
    input  logic [1:0]    flag_w_i,
    input  logic          pcs_i,
    input  logic          reg_w_i,
    input  logic          mem_w_i,
    input  logic          no_write_i,
    input  logic          it_start_i,
    input  logic [LW-1:0] it_len_i,
    input  logic [3:0]    it_cond_i,
    output logic          cond_ex_o,
    output logic          pc_src_o,
    output logic          reg_write_o,
    output logic          mem_write_o,
    output logic [3:0]    flags_o,
    output logic          it_active_o,
    output logic [LW-1:0] it_remaining_o
);

    localparam logic [BW:0] NB_W = (BW + 1)'(NUM_BANKS);

    logic                 fire;
    logic                 bank_ok;
    logic [3:0]           flags_rd;
    logic                 pass_instr;
    logic                 pass_it;
    logic                 in_block;
    logic                 cond_ex;
    logic                 flag_wr;
    logic [NUM_BANKS-1:0] bank_wr;
    logic [3:0]           bank_q [NUM_BANKS];

    assign fire = valid_i & ~stall_i;

    // Out-of-range bank selects read as 0000 and never write.
    assign bank_ok  = ({1'b0, bank_sel_i} < NB_W);
    assign flags_rd = bank_ok ? bank_q[bank_sel_i] : 4'b0000;
    assign flags_o  = flags_rd;

    cond_eval u_eval_instr (
        .flags (flags_rd),
        .cond  (cond_i),
        .pass  (pass_instr)
    );

    // Inside a block the instruction must satisfy both its own condition and
    // the block condition; the opening instruction is still outside the block.
    assign cond_ex   = pass_instr & (~in_block | pass_it);
    assign cond_ex_o = cond_ex;

    assign pc_src_o    = fire & cond_ex & pcs_i;
    assign reg_write_o = fire & cond_ex & reg_w_i & ~no_write_i;
    assign mem_write_o = fire & cond_ex & mem_w_i;

    // ---- flag banks: registered, no bypass to the current instruction ----
    assign flag_wr = fire & cond_ex & bank_ok;

    always_comb begin
        bank_wr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_wr[b] = flag_wr && (bank_sel_i == BW'(b));
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (reset) begin
                bank_q[b] <= 4'b0000;
            end else if (bank_wr[b]) begin
                if (flag_w_i[1]) begin
                    bank_q[b][N_IDX] <= alu_flags_i[N_IDX];
                    bank_q[b][Z_IDX] <= alu_flags_i[Z_IDX];
                end
                if (flag_w_i[0]) begin
                    bank_q[b][C_IDX] <= alu_flags_i[C_IDX];
                    bank_q[b][V_IDX] <= alu_flags_i[V_IDX];
                end
            end
        end
    end

`ifdef COND_IT_BLOCK_EN
    localparam logic [0:0] S_IDLE   = IT_IDLE;
    localparam logic [0:0] S_ACTIVE = IT_ACTIVE;

    logic [0:0]    state_q;
    logic [LW-1:0] count_q;
    logic [3:0]    it_cond_q;
    logic [LW-1:0] start_len;

    cond_eval u_eval_it (
        .flags (flags_rd),
        .cond  (it_cond_q),
        .pass  (pass_it)
    );

    assign in_block  = (state_q == S_ACTIVE);
    assign start_len = (it_len_i > LW'(IT_MAX)) ? LW'(IT_MAX) : it_len_i;

    // ---- predication FSM ----
    // An abort wins over everything else, including a stalled cycle.
    // Every fired block member consumes a slot whether or not it executes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            it_cond_q <= AL;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else if (fire) begin
            if (state_q == S_ACTIVE) begin
                count_q <= count_q - LW'(1);
                if (count_q == LW'(1)) begin
                    state_q <= S_IDLE;
                end
            end else if (it_start_i && (it_len_i != '0)) begin
                state_q   <= S_ACTIVE;
                count_q   <= start_len;
                it_cond_q <= it_cond_i;
            end
        end
    end

    assign it_active_o    = in_block;
    assign it_remaining_o = count_q;
`else
    logic unused_it;

    assign unused_it      = ^{flush_i, it_start_i, it_len_i, it_cond_i};
    assign in_block       = 1'b0;
    assign pass_it        = 1'b1;
    assign it_active_o    = 1'b0;
    assign it_remaining_o = '0;
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: stimulus pushes expected outputs from a
// behavioural model into a queue, a monitor pops and compares on the falling edge.
module tb_cond_exec_unit;

    localparam int NB  = 2;
    localparam int ITM = 4;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW  = $clog2(ITM + 1);

`ifdef COND_IT_BLOCK_EN
    localparam bit IT_EN = 1'b1;
`else
    localparam bit IT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_i, stall_i, flush_i;
    logic [3:0]    cond_i;
    logic [BW-1:0] bank_sel_i;
    logic [3:0]    alu_flags_i;
    logic [1:0]    flag_w_i;
    logic          pcs_i, reg_w_i, mem_w_i, no_write_i;
    logic          it_start_i;
    logic [LW-1:0] it_len_i;
    logic [3:0]    it_cond_i;
    logic          cond_ex_o, pc_src_o, reg_write_o, mem_write_o;
    logic [3:0]    flags_o;
    logic          it_active_o;
    logic [LW-1:0] it_remaining_o;

    cond_exec_unit #(.NUM_BANKS(NB), .IT_MAX(ITM)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .cond_i         (cond_i),
        .bank_sel_i     (bank_sel_i),
        .alu_flags_i    (alu_flags_i),
        .flag_w_i       (flag_w_i),
        .pcs_i          (pcs_i),
        .reg_w_i        (reg_w_i),
        .mem_w_i        (mem_w_i),
        .no_write_i     (no_write_i),
        .it_start_i     (it_start_i),
        .it_len_i       (it_len_i),
        .it_cond_i      (it_cond_i),
        .cond_ex_o      (cond_ex_o),
        .pc_src_o       (pc_src_o),
        .reg_write_o    (reg_write_o),
        .mem_write_o    (mem_write_o),
        .flags_o        (flags_o),
        .it_active_o    (it_active_o),
        .it_remaining_o (it_remaining_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v, st, fl;
        logic [3:0] c;
        logic [BW-1:0] bs;
        logic [3:0] af;
        logic [1:0] fw;
        bit         p, r, m, nw, its;
        logic [LW-1:0] il;
        logic [3:0] ic;
    } stim_t;

    typedef struct {
        bit         ce, pc, rw, mw;
        logic [3:0] fl;
        bit         act;
        int         rem;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Behavioural model state
    logic [3:0] m_flags [NB];
    bit         m_it_on;
    int         m_it_left;
    logic [3:0] m_it_cc;

    // ARM rule: bits [3:1] pick a base test, bit 0 inverts it; 1111 inverts "always".
    function automatic bit ev(input logic [3:0] c, input logic [3:0] f);
        bit n  = f[3];
        bit z  = f[2];
        bit cy = f[1];
        bit v  = f[0];
        bit base;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.st = 0; s.fl = 0; s.c = 4'b1110; s.bs = '0; s.af = 4'b0000;
        s.fw = 2'b00; s.p = 0; s.r = 0; s.m = 0; s.nw = 0; s.its = 0;
        s.il = '0; s.ic = 4'b1110;
        return s;
    endfunction

    function automatic stim_t instr(input logic [3:0] c, input logic [BW-1:0] bs);
        stim_t s = idle();
        s.v = 1; s.c = c; s.bs = bs; s.p = 1; s.r = 1; s.m = 1;
        return s;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_flags[b] = 4'b0000;
        m_it_on   = 0;
        m_it_left = 0;
        m_it_cc   = 4'b1110;
    endtask

    task automatic apply(input stim_t s);
        logic [3:0] fl;
        bit         ce, fire;
        exp_t       e;
        valid_i = s.v; stall_i = s.st; flush_i = s.fl; cond_i = s.c;
        bank_sel_i = s.bs; alu_flags_i = s.af; flag_w_i = s.fw;
        pcs_i = s.p; reg_w_i = s.r; mem_w_i = s.m; no_write_i = s.nw;
        it_start_i = s.its; it_len_i = s.il; it_cond_i = s.ic;
        fl   = (int'(s.bs) < NB) ? m_flags[s.bs] : 4'b0000;
        ce   = ev(s.c, fl) && (!m_it_on || ev(m_it_cc, fl));
        fire = s.v && !s.st;
        e.ce = ce; e.fl = fl; e.act = m_it_on; e.rem = m_it_left;
        e.pc = fire && ce && s.p;
        e.rw = fire && ce && s.r && !s.nw;
        e.mw = fire && ce && s.m;
        exp_q.push_back(e);
        @(posedge clk);
        if (fire && ce && int'(s.bs) < NB) begin
            if (s.fw[1]) m_flags[s.bs][3:2] = s.af[3:2];
            if (s.fw[0]) m_flags[s.bs][1:0] = s.af[1:0];
        end
        if (IT_EN) begin
            if (s.fl) begin
                m_it_on = 0; m_it_left = 0;
            end else if (fire) begin
                if (m_it_on) begin
                    m_it_left--;
                    if (m_it_left == 0) m_it_on = 0;
                end else if (s.its && s.il != 0) begin
                    m_it_on   = 1;
                    m_it_left = (int'(s.il) > ITM) ? ITM : int'(s.il);
                    m_it_cc   = s.ic;
                end
            end
        end
        #1;
    endtask

    task automatic reset_cycle();
        stim_t s = idle();
        reset = 1'b1;
        apply(s);
        model_reset();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("cond_ex",   32'(cond_ex_o),      32'(mon_e.ce));
            chk("pc_src",    32'(pc_src_o),       32'(mon_e.pc));
            chk("reg_write", 32'(reg_write_o),    32'(mon_e.rw));
            chk("mem_write", 32'(mem_write_o),    32'(mon_e.mw));
            chk("flags",     32'(flags_o),        32'(mon_e.fl));
            chk("it_active", 32'(it_active_o),    32'(mon_e.act));
            chk("it_remain", 32'(it_remaining_o), 32'(mon_e.rem));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        model_reset();
        s = idle();
        reset = 1'b1;
        valid_i = 0; stall_i = 0; flush_i = 0; cond_i = 4'b1110; bank_sel_i = '0;
        alu_flags_i = 0; flag_w_i = 0; pcs_i = 0; reg_w_i = 0; mem_w_i = 0;
        no_write_i = 0; it_start_i = 0; it_len_i = '0; it_cond_i = 4'b1110;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and basic conditions
        apply(idle());
        apply(instr(4'b0000, 1'b0));
        apply(instr(4'b1110, 1'b0));
        apply(instr(4'b1111, 1'b0));

        // CMP-style flag write, then EQ sees Z on the next instruction
        s = instr(4'b1110, 1'b0); s.fw = 2'b11; s.af = 4'b0100; s.nw = 1;
        apply(s);
        apply(instr(4'b0000, 1'b0));

        // Split write: C,V only
        s = instr(4'b1110, 1'b0); s.fw = 2'b01; s.af = 4'b1011;
        apply(s);
        apply(idle());

        // Bank isolation from a clean state
        reset_cycle();
        s = instr(4'b1110, 1'b1); s.fw = 2'b11; s.af = 4'b1000;
        apply(s);
        apply(instr(4'b0100, 1'b1));
        apply(instr(4'b0100, 1'b0));

        // Predication block: Z=1, NE block of 3 with a stall in the middle
        s = instr(4'b1110, 1'b0); s.fw = 2'b11; s.af = 4'b0100;
        apply(s);
        s = instr(4'b1110, 1'b0); s.its = 1; s.il = LW'(3); s.ic = 4'b0001;
        apply(s);
        apply(instr(4'b1110, 1'b0));
        s = instr(4'b1110, 1'b0); s.st = 1;
        apply(s);
        apply(instr(4'b1110, 1'b0));
        apply(instr(4'b1110, 1'b0));
        apply(instr(4'b1110, 1'b0));

        // Length clamp, then flush at count 2
        s = instr(4'b1110, 1'b0); s.its = 1; s.il = LW'(7); s.ic = 4'b0000;
        apply(s);
        apply(instr(4'b1110, 1'b0));
        apply(instr(4'b1110, 1'b0));
        s = idle(); s.fl = 1;
        apply(s);
        apply(idle());

        // Zero length is ignored; then reset mid-block
        s = instr(4'b1110, 1'b0); s.its = 1; s.il = '0;
        apply(s);
        s = instr(4'b1110, 1'b0); s.its = 1; s.il = LW'(4); s.ic = 4'b0001;
        apply(s);
        apply(instr(4'b1110, 1'b0));
        reset_cycle();
        apply(idle());

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
            end else begin
                s.v   = ($urandom_range(0, 9) < 8);
                s.st  = ($urandom_range(0, 99) < 15);
                s.fl  = !s.st && ($urandom_range(0, 99) < 3);
                s.c   = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
                s.bs  = BW'($urandom_range(0, (1 << BW) - 1));
                s.af  = 4'($urandom_range(0, 15));
                s.fw  = 2'($urandom_range(0, 3));
                s.p   = 1'($urandom_range(0, 1));
                s.r   = 1'($urandom_range(0, 1));
                s.m   = 1'($urandom_range(0, 1));
                s.nw  = ($urandom_range(0, 3) == 0);
                s.its = ($urandom_range(0, 9) == 0);
                s.il  = LW'($urandom_range(0, (1 << LW) - 1));
                s.ic  = 4'($urandom_range(0, 15));
                apply(s);
            end
        end
        apply(idle());

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
